// File: rtl/regs_bridge_if.sv
// Signal bundle between an upstream requester, the regs_bridge and its downstream channels.
// The bridge takes the slave view; whatever drives requests and models the channels takes the master view.
interface regs_bridge_if #(
    parameter int NCH  = 2,
    parameter int NREG = 8
);
    logic [31:0]         armaddr;
    logic [31:0]         armwdata;
    logic [3:0]          armwstrb;
    logic                armwr;
    logic                armreq;
    logic [31:0]         armrdata;
    logic                armack;
    logic                armerr;

    logic [19:0]         chaddr;
    logic [31:0]         chwdata;
    logic [3:0]          chwstrb;
    logic                chwr;
    logic [NCH-1:0]      chreq;
    logic [NCH-1:0]      chack;
    logic [NCH-1:0]      cherr;
    logic [NCH*32-1:0]   chrdata;

    logic [NREG*32-1:0]  regout;
    logic [31:0]         status;

    modport slave (
        input  armaddr, armwdata, armwstrb, armwr, armreq,
        input  chack, cherr, chrdata, status,
        output armrdata, armack, armerr,
        output chaddr, chwdata, chwstrb, chwr, chreq, regout
    );

    modport master (
        output armaddr, armwdata, armwstrb, armwr, armreq,
        output chack, cherr, chrdata, status,
        input  armrdata, armack, armerr,
        input  chaddr, chwdata, chwstrb, chwr, chreq, regout
    );
endinterface

// File: rtl/regs_bridge.sv
// Register bridge: answers local register accesses itself and forwards channel accesses,
// waiting for the channel's ack or a timeout. Only one transaction is outstanding at a time.
module regs_bridge #(
    parameter int NCH     = 2,
    parameter int NREG    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    regs_bridge_if.slave bus
);
    // state | meaning
    // IDLE  | nothing outstanding; local/unmapped requests are answered from here
    // WAIT  | channel request issued, waiting for chack or timeout
    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nxt;
    logic            req_q;
    logic            armed;
    logic [15:0]     cnt;
    logic [15:0]     errcnt;
    logic [31:0]     regs_q [NREG];

    logic [3:0]      tgt;
    logic [17:0]     off;
    logic            start, is_local, is_chan;
    logic [NCH-1:0]  chreq_nxt;
    logic            ack_hit, tmo, ch_err;
    logic [31:0]     ch_rdata;
    logic            loc_err, reg_we, clr_err;
    logic [31:0]     loc_rdata;
    logic            rsp_fire, rsp_err;
    logic [31:0]     rsp_rdata;
    logic            unused_bits;

    assign unused_bits = ^{bus.armaddr[31:24], bus.armaddr[1:0]};

    for (genvar i = 0; i < NREG; i++) begin : g_regout
        assign bus.regout[32*i +: 32] = regs_q[i];
    end

    always_comb begin
        tgt      = bus.armaddr[23:20];
        off      = bus.armaddr[19:2];
        // armed stays low after reset until armreq has been seen low once
        start    = (state == IDLE) && bus.armreq && !req_q && armed;
        is_local = (tgt == 4'd0);
        is_chan  = !is_local && (int'(tgt) <= NCH);

        chreq_nxt = '0;
        for (int k = 0; k < NCH; k++) chreq_nxt[k] = (int'(tgt) == k + 1);

        // chreq is one-hot on the active channel, so it masks out every other channel
        ack_hit  = (state == WAIT) && |(bus.chack & bus.chreq);
        tmo      = (state == WAIT) && (cnt == 16'(TIMEOUT - 1));
        ch_err   = |(bus.cherr & bus.chreq);
        ch_rdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.chreq[k]) ch_rdata |= bus.chrdata[32*k +: 32];
        end

        loc_err   = 1'b0;
        loc_rdata = '0;
        reg_we    = 1'b0;
        clr_err   = 1'b0;
        if (off == 18'd0) begin
            if (bus.armwr) loc_err = 1'b1;
            else           loc_rdata = bus.status;
        end else if (off == 18'd1) begin
            if (bus.armwr) clr_err = 1'b1;
            else           loc_rdata = {16'd0, errcnt};
        end else if ((off[17:6] == 12'd1) && (int'(off[5:0]) < NREG)) begin
            if (bus.armwr) begin
                reg_we = 1'b1;
            end else begin
                for (int i = 0; i < NREG; i++) begin
                    if (off[5:0] == 6'(i)) loc_rdata = regs_q[i];
                end
            end
        end else begin
            loc_err = 1'b1;
        end

        state_nxt = state;
        rsp_fire  = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_chan) begin
                        state_nxt = WAIT;
                    end else begin
                        rsp_fire  = 1'b1;
                        rsp_err   = !is_local || loc_err;
                        rsp_rdata = (is_local && !loc_err) ? loc_rdata : 32'd0;
                    end
                end
            end
            WAIT: begin
                if (ack_hit) begin
                    rsp_fire  = 1'b1;
                    rsp_err   = ch_err;
                    rsp_rdata = ch_rdata;
                    state_nxt = IDLE;
                end else if (tmo) begin
                    rsp_fire  = 1'b1;
                    rsp_err   = 1'b1;
                    rsp_rdata = 32'hDEAD_DEAD;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            armed        <= 1'b0;
            cnt          <= '0;
            errcnt       <= '0;
            bus.armack   <= 1'b0;
            bus.armerr   <= 1'b0;
            bus.armrdata <= '0;
            bus.chaddr   <= '0;
            bus.chwdata  <= '0;
            bus.chwstrb  <= '0;
            bus.chwr     <= 1'b0;
            bus.chreq    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state        <= state_nxt;
            req_q        <= bus.armreq;
            if (!bus.armreq) armed <= 1'b1;
            bus.armack   <= rsp_fire;
            bus.armerr   <= rsp_err;
            bus.armrdata <= rsp_rdata;

            if (rsp_fire && rsp_err) begin
                if (errcnt != 16'hFFFF) errcnt <= errcnt + 16'd1;
            end else if (start && is_local && clr_err) begin
                errcnt <= '0;
            end

            if (start && is_chan) begin
                bus.chreq   <= chreq_nxt;
                bus.chaddr  <= bus.armaddr[19:0];
                bus.chwdata <= bus.armwdata;
                bus.chwstrb <= bus.armwstrb;
                bus.chwr    <= bus.armwr;
                cnt         <= '0;
            end else if (ack_hit || tmo) begin
                bus.chreq   <= '0;
                cnt         <= '0;
            end else if (state == WAIT) begin
                cnt         <= cnt + 16'd1;
            end

            if (start && is_local && reg_we) begin
                for (int i = 0; i < NREG; i++) begin
                    if (off[5:0] == 6'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.armwstrb[b]) regs_q[i][8*b +: 8] <= bus.armwdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/regs_bridge.md
REGS_BRIDGE -- requirements
Module: regs_bridge

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of downstream channels (legal 1..14).
REQ-002 The block SHALL have parameter NREG, default 8, giving the number of local read/write words (legal 1..64).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for a channel ack (legal 1..65535).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 armaddr  in  32  request address; [23:20] selects target.
REQ-007 armwdata  in  32  write data.
REQ-008 armwstrb  in  4  write byte strobes.
REQ-009 armwr  in  1  1=write, 0=read.
REQ-010 armreq  in  1  request level; rising edge starts a transaction.
REQ-011 armrdata  out  32  read data, valid with armack.
REQ-012 armack  out  1  one-cycle completion pulse.
REQ-013 armerr  out  1  error flag, valid with armack.
REQ-014 chaddr  out  20  channel address (armaddr[19:0]), shared by all channels.
REQ-015 chwdata, chwstrb, chwr  out  32/4/1  channel write data, strobes, direction.
REQ-016 chreq  out  NCH  one-hot channel request, held until ack or timeout.
REQ-017 chack, cherr  in  NCH  per-channel ack and error, sampled only for the active channel.
REQ-018 chrdata  in  NCH*32  per-channel read data, channel k at [32k+31:32k].
REQ-019 regout  out  NREG*32  local register contents, word i at [32i+31:32i].
REQ-020 status  in  32  read-only status word.

Function
REQ-021 Start condition: in IDLE, armreq=1 while its previous-cycle registered value was 0; edges outside IDLE SHALL be ignored, not queued.
REQ-022 Decode on armaddr[23:20]: 0 = local; 1..NCH = channel (value-1); any other value = unmapped.
REQ-023 Local and unmapped accesses SHALL complete with armack exactly one cycle after the start edge, with no state change.
REQ-024 Local map (armaddr[19:0] with [1:0] ignored): 0x000 RO status; 0x004 errcnt (16-bit, zero-extended on read; any write clears it); 0x100+4i RW regout word i for i<NREG.
REQ-025 Local writes SHALL update only the bytes whose armwstrb bit is 1.
REQ-026 Writes to 0x000 and reads/writes of unlisted local offsets or unmapped targets SHALL ack with armerr=1 and armrdata=0.
REQ-027 Channel access: the cycle after start, chreq[k]=1, chaddr/chwdata/chwstrb/chwr are loaded, and state=WAIT.
REQ-028 In WAIT, when chack[k]=1 is sampled: chreq=0 on the next cycle, with armack=1, armerr=cherr[k], armrdata=chrdata slice k in that same cycle; state returns to IDLE.
REQ-029 In WAIT, a 16-bit counter SHALL count cycles from 0; on reaching TIMEOUT without chack[k], chreq SHALL drop and the block SHALL ack with armerr=1 and armrdata=32'hDEADDEAD.
REQ-030 If chack[k] and timeout occur in the same cycle, the ack SHALL win.
REQ-031 chack/cherr of inactive channels and any chack in IDLE SHALL be ignored.
REQ-032 errcnt SHALL increment, saturating at 0xFFFF, on every armack with armerr=1; a clearing write that itself completes without error leaves errcnt=0.
REQ-033 State machine: IDLE, WAIT only; at most one transaction is outstanding.

Reset
REQ-034 When rstn=0 at a clock edge: state=IDLE, all outputs 0, regout=0, errcnt=0, counter=0, edge register=0.
REQ-035 Reset during WAIT SHALL drop chreq on the next cycle and SHALL NOT produce armack.
REQ-036 With armreq held at 1 through reset release, no transaction SHALL start until armreq falls and rises again.

Verification
REQ-037 Write 0x00000104, data 0xAABBCCDD, strb 0b0101 over regout word 1=0 -> 1 cycle later armack=1, armerr=0; regout word 1=0x00BB00DD.
REQ-038 Read 0x00100010 with channel 0 acking 3 cycles after chreq, chrdata=0x12345678 -> chaddr=0x00010, armack 1 cycle after chack, armrdata=0x12345678, armerr=0.
REQ-039 Read 0x00200000 with channel 1 never acking, TIMEOUT=255 -> chreq[1] drops after 255 cycles; armack, armerr=1, armrdata=0xDEADDEAD; errcnt=1.
REQ-040 Access 0x00F00000 (unmapped, NCH=2) -> armack 1 cycle later, armerr=1, armrdata=0; then write 0x00000004 -> errcnt reads 0.
REQ-041 Assert rstn=0 while in WAIT with chreq[0]=1 -> chreq=0 next cycle, no armack; a later chack[0] is ignored.
